alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Parametrised, multi-cycle successor to the 8-bit core ALU, for the 16/32-bit accumulator modes of the extended core.
- Processes one SLICE-bit slice per clock through a shared slice datapath with binary or BCD arithmetic.
- Uses a start/busy/done handshake and produces registered result and flags.
- Sits beside the existing 8-bit ALU; operand muxing stays outside the block.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of SLICE, minimum SLICE.
- SLICE, 8, bits processed per cycle; multiple of 4.
- NSLICE (local), WIDTH/SLICE, cycles per operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0=ORA, 1=AND, 2=EOR, 3=ADC, 4=SBC, 5=ROR, 6=ROL, 7=PSA (pass a).
- dec  in  1  BCD mode; affects ADC/SBC only.
- c_in  in  1  carry in (ADC/SBC/ROR/ROL).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; inverted internally for SBC.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  WIDTH  registered result; held until next accepted start.
- c_out, v_out, n_out, z_out  out  1 each  registered flags.
- bittest_out  out  1  |result for AND, else 0.

Behaviour:
- Reset (async assert): busy=0, done=0, result=0, all flags=0, bittest_out=0, slice counter=0. Deassertion is synchronised by the surrounding reset logic.
- Accept: start=1 && busy=0 at edge k:
  - latch a, b (b inverted when op=SBC), op, dec, c_in into the carry register;
  - busy=1 after edge k.
- Start while busy=1 is ignored; no queueing.
- Execution: edges k+1 .. k+NSLICE each process one slice and write it into the result register.
  - Slice order is LSB to MSB for every op except ROR, which runs MSB to LSB.
  - The carry register chains between slices.
- Completion, after edge k+NSLICE: busy=0, done=1 for exactly one cycle, flags updated.
- Latency is NSLICE cycles from the accept edge to done. A start sampled in the done cycle is accepted, giving back-to-back throughput of one op per NSLICE+1 cycles.
- ADC/SBC, per 4-bit nibble with 5-bit sum s = x + y + cy:
  - binary: nibble = s[3:0], cy = s[4];
  - ADC with dec: if s > 9 then s = s + 6 and cy = 1;
  - SBC with dec: if s[4] = 0 (borrow) then nibble = s[3:0] − 6 mod 16; cy = s[4].
- Logic ops: bitwise, no carry chain. c_out = 0 for ORA/AND/EOR/PSA.
- ROR: each slice shifts right; the incoming carry enters the slice MSB and the slice LSB becomes the next carry. c_out = original a[0].
- ROL: mirror of ROR, LSB-first; c_out = original a[WIDTH-1].
- Flags at done:
  - n_out = result[WIDTH-1];
  - z_out = (result == 0);
  - c_out = final carry register;
  - v_out = a[W-1] == b'[W-1] && a[W-1] != binary_sum[W-1] for ADC/SBC (b' is post-inversion; the binary sum of the top nibble is taken before decimal adjust), else 0.
- bittest_out updates with the flags at done.
- Outputs hold between operations. result is partially written during busy and is valid only from done onward.
- Reset mid-operation aborts immediately: all outputs return to reset values and no done is issued.
- WIDTH == SLICE degenerates to single-slice, 1-cycle latency. Behaviour must match the 8-bit ALU for ORA/AND/EOR/ADC/SBC(binary)/ROR/PSA, with PSA c_out = 0.

Test Plan:
- WIDTH=16: ADC dec=1, a=0x0999, b=0x0001, c_in=0 -> done exactly 2 cycles after accept; result=0x1000, C=0, Z=0, N=0.
- SBC dec=1, a=0x1000, b=0x0001, c_in=1 -> result=0x0999, C=1, V=0.
- ADC dec=0, a=0x7FFF, b=0x0001, c_in=0 -> result=0x8000, V=1, N=1, C=0.
- ROR a=0x0001, c_in=1 -> 0x8000, C=1. Then ROL a=0x8000, c_in=0 -> 0x0000, C=1, Z=1.
- AND a=0x00F0, b=0x0F0F -> 0x0000, Z=1, bittest_out=0. Also check that start held high during busy issues exactly one done.
- Back-to-back start in the done cycle is accepted. reset_n pulsed low mid-ADC -> busy/done/result/flags=0 immediately, no done pulse. Repeat at WIDTH=32 and WIDTH=SLICE=8.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: start/busy/done handshake, operands and registered results of the sequential ALU
interface alu_seq_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic             dec;
    logic             c_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             v_out;
    logic             n_out;
    logic             z_out;
    logic             bittest_out;
    modport master (
        output start, op, dec, c_in, a, b,
        input  busy, done, result, c_out, v_out, n_out, z_out, bittest_out
    );
    modport slave (
        input  start, op, dec, c_in, a, b,
        output busy, done, result, c_out, v_out, n_out, z_out, bittest_out
    );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle slice-serial ALU with binary/BCD arithmetic and registered flags
module alu_seq_unit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_seq_unit_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [2:0] {
        OP_ORA, OP_AND, OP_EOR, OP_ADC, OP_SBC, OP_ROR, OP_ROL, OP_PSA
    } op_t;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    cnt, idx;
    op_t              op_r;
    logic             dec_r, cy, cy_nx, cyt, top3, ad, sb, arith, last, accept;
    logic [WIDTH-1:0] a_r, b_r, result, res_nx;
    logic [SLICE-1:0] xs, ys, ar, sl;
    logic [4:0]       s;
    logic             done_q, c_q, v_q, n_q, z_q, bt_q;
    int               base;
    assign accept = (state == IDLE) && bus.start;
    assign last   = cnt == CW'(NSLICE - 1);
    assign arith  = (op_r == OP_ADC) || (op_r == OP_SBC);
    // Sequencer: idle until an accepted start, then one slice per cycle
    always_comb begin
        state_nx = (state == IDLE) ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    // State register and slice counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= accept ? '0 : (state == RUN ? cnt + 1'b1 : cnt);
        end
    end
    // Slice datapath: ROR walks MSB-first so its carry enters the top of the word
    always_comb begin
        idx  = (op_r == OP_ROR) ? CW'(NSLICE - 1) - cnt : cnt;
        base = int'(idx) * SLICE;
        xs   = a_r[base +: SLICE];
        ys   = b_r[base +: SLICE];
        ar   = '0;
        s    = '0;
        ad   = 1'b0;
        sb   = 1'b0;
        top3 = 1'b0;
        cyt  = cy;
        for (int n = 0; n < SLICE / 4; n++) begin
            s    = {1'b0, xs[4*n +: 4]} + {1'b0, ys[4*n +: 4]} + {4'd0, cyt};
            ad   = dec_r && (op_r == OP_ADC) && (s > 5'd9);
            sb   = dec_r && (op_r == OP_SBC) && !s[4];
            ar[4*n +: 4] = s[3:0] + (ad ? 4'd6 : 4'd0) - (sb ? 4'd6 : 4'd0);
            cyt  = ad | s[4];
            top3 = s[3];
        end
        sl = (op_r == OP_ORA) ? xs | ys :
             (op_r == OP_AND) ? xs & ys :
             (op_r == OP_EOR) ? xs ^ ys :
             arith            ? ar :
             (op_r == OP_ROR) ? {cy, xs[SLICE-1:1]} :
             (op_r == OP_ROL) ? {xs[SLICE-2:0], cy} : xs;
        cy_nx = arith ? cyt : (op_r == OP_ROR) ? xs[0] : (op_r == OP_ROL) ? xs[SLICE-1] : 1'b0;
        res_nx = result;
        res_nx[base +: SLICE] = sl;
    end
    // Operand capture on accept, slice write-back while running, flags on the final slice
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_ORA;
            dec_r  <= 1'b0;
            cy     <= 1'b0;
            result <= '0;
            done_q <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            bt_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_r   <= bus.a;
                b_r   <= (op_t'(bus.op) == OP_SBC) ? ~bus.b : bus.b;
                op_r  <= op_t'(bus.op);
                dec_r <= bus.dec;
                cy    <= bus.c_in;
            end else if (state == RUN) begin
                result <= res_nx;
                cy     <= cy_nx;
                if (last) begin
                    done_q <= 1'b1;
                    c_q    <= cy_nx;
                    v_q    <= arith && (a_r[WIDTH-1] == b_r[WIDTH-1]) && (a_r[WIDTH-1] != top3);
                    n_q    <= res_nx[WIDTH-1];
                    z_q    <= ~|res_nx;
                    bt_q   <= (op_r == OP_AND) && |res_nx;
                end
            end
        end
    end
    assign bus.busy        = state == RUN;
    assign bus.done        = done_q;
    assign bus.result      = result;
    assign bus.c_out       = c_q;
    assign bus.v_out       = v_q;
    assign bus.n_out       = n_q;
    assign bus.z_out       = z_q;
    assign bus.bittest_out = bt_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: drives 8/16/32-bit instances in lockstep against a word-level reference model
module tb_alu_seq_unit;
    typedef struct packed {
        logic [31:0] res;
        logic        c, v, n, z, bt;
    } exp_t;
    localparam int W[3] = '{8, 16, 32};
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic        dec = 1'b0;
    logic        c_in = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] o_res[3];
    logic        o_busy[3], o_done[3], o_c[3], o_v[3], o_n[3], o_z[3], o_bt[3];
    exp_t        q0[$], q1[$], q2[$];
    exp_t        hld[3];
    int          cnt[3];
    logic        mdone[3];
    int          n_assert = 0;
    int          n_fail = 0;
    int          dcnt16 = 0;
    int          d0;
    always #5 clk = ~clk;
    alu_seq_unit_if #(.WIDTH(8))  b8 ();
    alu_seq_unit_if #(.WIDTH(16)) b16 ();
    alu_seq_unit_if #(.WIDTH(32)) b32 ();
    alu_seq_unit #(.WIDTH(8),  .SLICE(8)) u8  (.clk(clk), .reset_n(reset_n), .bus(b8.slave));
    alu_seq_unit #(.WIDTH(16), .SLICE(8)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16.slave));
    alu_seq_unit #(.WIDTH(32), .SLICE(8)) u32 (.clk(clk), .reset_n(reset_n), .bus(b32.slave));
    assign b8.start  = start;  assign b8.op  = op;  assign b8.dec  = dec;  assign b8.c_in  = c_in;
    assign b16.start = start;  assign b16.op = op;  assign b16.dec = dec;  assign b16.c_in = c_in;
    assign b32.start = start;  assign b32.op = op;  assign b32.dec = dec;  assign b32.c_in = c_in;
    assign b8.a  = a[7:0];   assign b8.b  = b[7:0];
    assign b16.a = a[15:0];  assign b16.b = b[15:0];
    assign b32.a = a;        assign b32.b = b;
    assign o_res[0] = 32'(b8.result);  assign o_res[1] = 32'(b16.result);  assign o_res[2] = b32.result;
    assign o_busy[0] = b8.busy;  assign o_busy[1] = b16.busy;  assign o_busy[2] = b32.busy;
    assign o_done[0] = b8.done;  assign o_done[1] = b16.done;  assign o_done[2] = b32.done;
    assign o_c[0] = b8.c_out;  assign o_c[1] = b16.c_out;  assign o_c[2] = b32.c_out;
    assign o_v[0] = b8.v_out;  assign o_v[1] = b16.v_out;  assign o_v[2] = b32.v_out;
    assign o_n[0] = b8.n_out;  assign o_n[1] = b16.n_out;  assign o_n[2] = b32.n_out;
    assign o_z[0] = b8.z_out;  assign o_z[1] = b16.z_out;  assign o_z[2] = b32.z_out;
    assign o_bt[0] = b8.bittest_out;  assign o_bt[1] = b16.bittest_out;  assign o_bt[2] = b32.bittest_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Word-level reference: whole-word binary add, whole-word rotates, nibble walk only for BCD
    function automatic exp_t model(input logic [2:0] mo, input logic md, input logic mc,
                                   input logic [31:0] ma, input logic [31:0] mb, input int w);
        logic [32:0] one = 33'd1;
        logic [31:0] m, bb, r;
        logic [32:0] sum;
        logic        c, tb;
        int          s, cy;
        exp_t        e;
        m  = 32'((one << w) - 33'd1);
        ma = ma & m;
        mb = mb & m;
        bb = (mo == 3'd4) ? (~mb & m) : mb;
        r  = '0;
        c  = 1'b0;
        tb = 1'b0;
        case (mo)
            3'd0: r = ma | mb;
            3'd1: r = ma & mb;
            3'd2: r = ma ^ mb;
            3'd3, 3'd4: begin
                if (!md) begin
                    sum = {1'b0, ma} + {1'b0, bb} + 33'(mc);
                    r   = sum[31:0] & m;
                    c   = sum[w];
                    tb  = sum[w-1];
                end else begin
                    cy = int'(mc);
                    for (int i = 0; i < w / 4; i++) begin
                        s  = int'(ma[4*i +: 4]) + int'(bb[4*i +: 4]) + cy;
                        tb = s[3];
                        if (mo == 3'd3) begin
                            if (s > 9) begin
                                s  = s + 6;
                                cy = 1;
                            end else cy = 0;
                        end else begin
                            cy = s >> 4;
                            if (cy == 0) s = s - 6;
                        end
                        r[4*i +: 4] = 4'(s);
                    end
                    c = cy[0];
                end
            end
            3'd5: begin
                r = (ma >> 1) | (32'(mc) << (w - 1));
                c = ma[0];
            end
            3'd6: begin
                r = ((ma << 1) | 32'(mc)) & m;
                c = ma[w-1];
            end
            default: r = ma;
        endcase
        e.res = r;
        e.c   = c;
        e.v   = (mo == 3'd3 || mo == 3'd4) && (ma[w-1] == bb[w-1]) && (ma[w-1] != tb);
        e.n   = r[w-1];
        e.z   = (r == 0);
        e.bt  = (mo == 3'd1) && (r != 0);
        return e;
    endfunction

    function automatic void push(input int u, input exp_t e);
        case (u)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t pop(input int u);
        exp_t e = '0;
        case (u)
            0: if (q0.size() > 0) e = q0.pop_front();
            1: if (q1.size() > 0) e = q1.pop_front();
            default: if (q2.size() > 0) e = q2.pop_front();
        endcase
        return e;
    endfunction

    // Scoreboard feed: bench-side busy tracking decides acceptance, pushes at accept, pops at done
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int u = 0; u < 3; u++) begin
                cnt[u]   = 0;
                mdone[u] = 1'b0;
                hld[u]   = '0;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (cnt[u] > 0) begin
                    cnt[u]--;
                    mdone[u] = (cnt[u] == 0);
                    if (mdone[u]) hld[u] = pop(u);
                end else begin
                    mdone[u] = 1'b0;
                    if (start) begin
                        push(u, model(op, dec, c_in, a, b, W[u]));
                        cnt[u] = W[u] / 8;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of handshake and, whenever idle, the held result and flags
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_done[1]) dcnt16++;
            for (int u = 0; u < 3; u++) begin
                chk($sformatf("u%0d_busy", W[u]), 32'(o_busy[u]), 32'(cnt[u] != 0));
                chk($sformatf("u%0d_done", W[u]), 32'(o_done[u]), 32'(mdone[u]));
                if (cnt[u] == 0) begin
                    chk($sformatf("u%0d_result", W[u]), o_res[u], hld[u].res);
                    chk($sformatf("u%0d_flags_cvnzb", W[u]),
                        32'({o_c[u], o_v[u], o_n[u], o_z[u], o_bt[u]}),
                        32'({hld[u].c, hld[u].v, hld[u].n, hld[u].z, hld[u].bt}));
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("%s_u%0d_busy_done", tag, W[u]), 32'({o_busy[u], o_done[u]}), 0);
            chk($sformatf("%s_u%0d_result", tag, W[u]), o_res[u], 0);
            chk($sformatf("%s_u%0d_flags", tag, W[u]),
                32'({o_c[u], o_v[u], o_n[u], o_z[u], o_bt[u]}), 0);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && (o_busy[0] || o_busy[1] || o_busy[2]); i++) @(negedge clk);
        chk("idle_timeout", 32'({o_busy[0], o_busy[1], o_busy[2]}), 0);
    endtask

    task automatic run(input logic [2:0] o, input logic d, input logic ci,
                       input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        op    = o;
        dec   = d;
        c_in  = ci;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic chk_r(input string tag, input int u, input logic [31:0] r, input logic [3:0] cvnz);
        chk($sformatf("%s_u%0d_res", tag, W[u]), o_res[u], r);
        chk($sformatf("%s_u%0d_cvnz", tag, W[u]), 32'({o_c[u], o_v[u], o_n[u], o_z[u]}), 32'(cvnz));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;
        run(3'd3, 1'b1, 1'b0, 32'h0999, 32'h0001);
        chk_r("adc_bcd", 1, 32'h1000, 4'b0000);
        chk_r("adc_bcd", 2, 32'h1000, 4'b0000);
        chk_r("adc_bcd", 0, 32'h00, 4'b1001);
        run(3'd4, 1'b1, 1'b1, 32'h1000, 32'h0001);
        chk_r("sbc_bcd", 1, 32'h0999, 4'b1000);
        chk_r("sbc_bcd", 2, 32'h0999, 4'b1000);
        chk_r("sbc_bcd", 0, 32'h99, 4'b0010);
        run(3'd3, 1'b0, 1'b0, 32'h7FFF, 32'h0001);
        chk_r("adc_ovf", 1, 32'h8000, 4'b0110);
        chk_r("adc_ovf", 2, 32'h8000, 4'b0000);
        chk_r("adc_ovf", 0, 32'h00, 4'b1001);
        run(3'd5, 1'b0, 1'b1, 32'h0001, 32'h0);
        chk_r("ror", 1, 32'h8000, 4'b1010);
        chk_r("ror", 2, 32'h80000000, 4'b1010);
        chk_r("ror", 0, 32'h80, 4'b1010);
        run(3'd6, 1'b0, 1'b0, 32'h8000, 32'h0);
        chk_r("rol", 1, 32'h0000, 4'b1001);
        chk_r("rol", 2, 32'h00010000, 4'b0000);
        chk_r("rol", 0, 32'h00, 4'b0001);
        run(3'd1, 1'b0, 1'b0, 32'h00F0, 32'h0F0F);
        chk_r("and_zero", 1, 32'h0000, 4'b0001);
        chk("and_zero_bittest16", 32'(o_bt[1]), 0);
        run(3'd1, 1'b0, 1'b0, 32'hFFFF, 32'h0F0F);
        chk_r("and_nz", 1, 32'h0F0F, 4'b0000);
        chk("and_nz_bittest16", 32'(o_bt[1]), 1);
        // start held across the whole 16-bit busy window
        d0 = dcnt16;
        @(negedge clk);
        op    = 3'd0;
        a     = 32'h1234;
        b     = 32'h00F0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("held_start_dones16", 32'(dcnt16 - d0), 1);
        // start kept high into the done cycle: second op must be accepted
        d0 = dcnt16;
        @(negedge clk);
        op    = 3'd3;
        dec   = 1'b0;
        c_in  = 1'b0;
        a     = 32'h0101;
        b     = 32'h0202;
        start = 1'b1;
        for (int i = 0; i < 10 && !o_done[1]; i++) @(negedge clk);
        chk("b2b_first_done16", 32'(o_done[1]), 1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy16", 32'(o_busy[1]), 1);
        wait_idle();
        @(negedge clk);
        chk("b2b_dones16", 32'(dcnt16 - d0), 2);
        chk_r("b2b", 1, 32'h0303, 4'b0000);
        // reset in the middle of an ADC
        @(negedge clk);
        op    = 3'd3;
        a     = 32'h12345678;
        b     = 32'h11111111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("midop_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset("after_abort");
        run(3'd7, 1'b0, 1'b1, 32'hA5A5C3C3, 32'h0);
        chk_r("psa", 1, 32'hC3C3, 4'b0010);
        for (int k = 0; k < 24; k++)
            run(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
